bdd_tree_loader: RTL

Host-side writer for the BDD accelerator's node-coefficient RAM and child-pointer RAM. It is the counterpart of the tree traversal engine, which only reads these memories.
- Accepts a byte stream over a valid/ready handshake.
- Assembles 32-bit coefficient words {c1,c2,c3,c4} and 18-bit child words {left[8:0], right[8:0]}.
- Issues one write per node into each RAM, then reports done or err.

---
 rtl/bdd_pkg.sv | 25 ++
 rtl/bdd_byte_packer.sv | 46 ++++
 rtl/bdd_tree_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bdd_pkg.sv
// rtl/bdd_pkg.sv - shared FSM states, record geometry and child-word field offsets
// Child-word offsets are shared with the traversal engine that reads the same RAM.
package bdd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_COEF,
    ST_CHILD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned COEF_BYTES  = 4;
  localparam int unsigned CHILD_BYTES = 3;
  localparam int unsigned CLASS_BIT   = 8;
  localparam int unsigned CHILD_HALF  = 9;

  localparam int unsigned CHILD_LEFT_LSB  = CHILD_HALF;
  localparam int unsigned CHILD_LEFT_MSB  = 2 * CHILD_HALF - 1;
  localparam int unsigned CHILD_RIGHT_LSB = 0;
  localparam int unsigned CHILD_RIGHT_MSB = CHILD_HALF - 1;

endpackage

// File: rtl/bdd_byte_packer.sv
// rtl/bdd_byte_packer.sv - MSB-first byte shift-in assembler with a byte counter
// Keeps only the low OUT_W-8 bits; leading bytes beyond OUT_W simply fall off the top.
module bdd_byte_packer #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned OUT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [OUT_W-1:0] word_next,
  output logic             at_last
);

  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [OUT_W-9:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign word_next = {word_q, byte_in};
  assign at_last   = (cnt_q == CW'(NBYTES - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = word_next[OUT_W-9:0];
      cnt_d  = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bdd_tree_loader.sv
// rtl/bdd_tree_loader.sv - byte-stream writer for the BDD node-coefficient and child-pointer RAMs
// Optional trailing XOR checksum byte enabled by defining BDD_LOADER_CSUM_EN.
module bdd_tree_loader
  import bdd_pkg::*;
#(
  parameter int unsigned NODE_WIDTH  = 32,
  parameter int unsigned CHILD_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DEPTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  node_we,
  output logic [ADDR_WIDTH-1:0] node_addr,
  output logic [NODE_WIDTH-1:0] node_wdata,
  output logic                  child_we,
  output logic [ADDR_WIDTH-1:0] child_addr,
  output logic [CHILD_WIDTH-1:0] child_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   node_count
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [ADDR_WIDTH-1:0]  k_q, k_d;
  logic                   node_we_q, node_we_d;
  logic [ADDR_WIDTH-1:0]  node_addr_q, node_addr_d;
  logic [NODE_WIDTH-1:0]  node_wdata_q, node_wdata_d;
  logic                   child_we_q, child_we_d;
  logic [ADDR_WIDTH-1:0]  child_addr_q, child_addr_d;
  logic [CHILD_WIDTH-1:0] child_wdata_q, child_wdata_d;

  logic                   accept, pack_clr, coef_shift, child_shift;
  logic                   coef_at_last, child_at_last, last_node;
  logic [NODE_WIDTH-1:0]  coef_word;
  logic [CHILD_WIDTH-1:0] child_word;

  assign in_ready    = (state_q == ST_HDR) || (state_q == ST_COEF) ||
                       (state_q == ST_CHILD) || (state_q == ST_CSUM);
  assign busy        = in_ready;
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);
  assign accept      = in_valid && in_ready;
  assign pack_clr    = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
  assign coef_shift  = accept && (state_q == ST_COEF);
  assign child_shift = accept && (state_q == ST_CHILD);
  assign last_node   = ({1'b0, k_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == count_q;

  bdd_byte_packer #(.NBYTES(COEF_BYTES), .OUT_W(NODE_WIDTH)) u_coef_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .shift_en  (coef_shift),
    .byte_in   (in_data),
    .word_next (coef_word),
    .at_last   (coef_at_last)
  );

  bdd_byte_packer #(.NBYTES(CHILD_BYTES), .OUT_W(CHILD_WIDTH)) u_child_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pack_clr),
    .shift_en  (child_shift),
    .byte_in   (in_data),
    .word_next (child_word),
    .at_last   (child_at_last)
  );

`ifdef BDD_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;

  // Every frame byte ahead of the checksum itself, header included.
  always_comb begin
    csum_d = csum_q;
    if (pack_clr) begin
      csum_d = '0;
    end else if (accept && (state_q != ST_CSUM)) begin
      csum_d = csum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    k_d           = k_q;
    node_we_d     = 1'b0;
    node_addr_d   = node_addr_q;
    node_wdata_d  = node_wdata_q;
    child_we_d    = 1'b0;
    child_addr_d  = child_addr_q;
    child_wdata_d = child_wdata_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          k_d     = '0;
        end
      end
      ST_HDR: begin
        if (in_valid) begin
          if ((in_data == 8'd0) || ({1'b0, in_data} > 9'(DEPTH))) begin
            state_d = ST_ERR;
          end else begin
            count_d = (ADDR_WIDTH+1)'(in_data);
            k_d     = '0;
            state_d = ST_COEF;
          end
        end
      end
      ST_COEF: begin
        if (in_valid && coef_at_last) begin
          node_we_d    = 1'b1;
          node_addr_d  = k_q;
          node_wdata_d = coef_word;
          state_d      = ST_CHILD;
        end
      end
      ST_CHILD: begin
        if (in_valid && child_at_last) begin
          child_we_d    = 1'b1;
          child_addr_d  = k_q;
          child_wdata_d = child_word;
          if (last_node) begin
`ifdef BDD_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            k_d     = k_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            state_d = ST_COEF;
          end
        end
      end
`ifdef BDD_LOADER_CSUM_EN
      ST_CSUM: begin
        if (in_valid) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      k_q           <= '0;
      node_we_q     <= 1'b0;
      node_addr_q   <= '0;
      node_wdata_q  <= '0;
      child_we_q    <= 1'b0;
      child_addr_q  <= '0;
      child_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      k_q           <= k_d;
      node_we_q     <= node_we_d;
      node_addr_q   <= node_addr_d;
      node_wdata_q  <= node_wdata_d;
      child_we_q    <= child_we_d;
      child_addr_q  <= child_addr_d;
      child_wdata_q <= child_wdata_d;
    end
  end

  assign node_we     = node_we_q;
  assign node_addr   = node_addr_q;
  assign node_wdata  = node_wdata_q;
  assign child_we    = child_we_q;
  assign child_addr  = child_addr_q;
  assign child_wdata = child_wdata_q;
  assign node_count  = count_q;

endmodule
